// File: rtl/phi_meter.sv
// PHI receive-side checker: measures period and high time of the divided CPU
// clock in master-clock cycles, classifies the divide ratio and tracks lock.
//
// state   | meaning
// IDLE    | waiting for the first PHI rise; nothing is captured
// MEASURE | capturing periods, counting identical classified periods
// LOCKED  | ratio confirmed; any differing period drops lock with err
module phi_meter #(
    parameter int CNT_W     = 6,
    parameter int NTSC_DIV  = 12,
    parameter int PAL_DIV   = 16,
    parameter int DENDY_DIV = 15,
    parameter int LOCK_N    = 4
) (
    input  logic             CLK,
    input  logic             nRES,
    input  logic             phi_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic [1:0]       mode,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] NTSC_C  = CNT_W'(NTSC_DIV);
    localparam logic [CNT_W-1:0] PAL_C   = CNT_W'(PAL_DIV);
    localparam logic [CNT_W-1:0] DENDY_C = CNT_W'(DENDY_DIV);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt, hcnt;
    state_t           state, state_d;
    logic [1:0]       cand, cand_d, cls, mode_d;
    logic [3:0]       match_cnt, match_d, match_inc;
    logic             locked_d, err_d, cap, timeout;

    assign rise      = s2 & ~s3;
    assign timeout   = (state != IDLE) && (cnt == CNT_MAX);
    assign match_inc = match_cnt + 4'd1;

    // Synchronizer plus edge flop, and the free-running period/high counters.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            cnt  <= '0;
            hcnt <= '0;
        end else begin
            s1 <= phi_in;
            s2 <= s1;
            s3 <= s2;
            if (rise) begin
                cnt  <= CNT_ONE;
                hcnt <= CNT_ONE;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNT_ONE;
                if (s2 && (hcnt != CNT_MAX))
                    hcnt <= hcnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        cls = 2'd0;
        if (cnt == NTSC_C)
            cls = 2'd1;
        else if (cnt == PAL_C)
            cls = 2'd2;
        else if (cnt == DENDY_C)
            cls = 2'd3;
    end

    always_comb begin
        state_d  = state;
        cand_d   = cand;
        match_d  = match_cnt;
        locked_d = locked;
        mode_d   = mode;
        err_d    = 1'b0;
        cap      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cand_d  = 2'd0;
                    match_d = 4'd0;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    mode_d   = 2'd0;
                end else if (rise) begin
                    cap = 1'b1;
                    if ((cls != 2'd0) && (cls == cand)) begin
                        match_d = match_inc;
                    end else begin
                        cand_d  = cls;
                        match_d = {3'b000, cls != 2'd0};
                    end
                    if (match_d >= LOCK_C) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        mode_d   = cand_d;
                    end
                end
            end
            LOCKED: begin
                if (timeout) begin
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    mode_d   = 2'd0;
                end else if (rise) begin
                    cap = 1'b1;
                    if (cls != mode) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        mode_d   = 2'd0;
                        state_d  = MEASURE;
                        cand_d   = cls;
                        match_d  = {3'b000, cls != 2'd0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status registers update together with the capture so locked and the
    // final meas_valid appear on the same cycle.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state      <= IDLE;
            cand       <= 2'd0;
            match_cnt  <= 4'd0;
            locked     <= 1'b0;
            mode       <= 2'd0;
            err        <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
        end else begin
            state      <= state_d;
            cand       <= cand_d;
            match_cnt  <= match_d;
            locked     <= locked_d;
            mode       <= mode_d;
            err        <= err_d;
            meas_valid <= cap;
            if (cap) begin
                period    <= cnt;
                high_time <= hcnt;
            end
        end
    end

endmodule
